lcd_char_arbiter: RTL



---
 rtl/lcd_char_arbiter_pkg.sv | 42 ++++
 rtl/lcd_char_arbiter_if.sv | 57 +++++
 rtl/lcd_char_arbiter_rr_pick2.sv | 30 +++
 rtl/lcd_char_arbiter.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/lcd_char_arbiter_pkg.sv
// Shared definitions for the LCD character-draw arbiter.
//   - FSM state encoding
//   - font select constants for en_size
//   - LCD coordinate / ASCII field widths
//   - latched character-request record and a packing helper
package lcd_char_arbiter_pkg;

  localparam int LCD_COORD_W = 9;
  localparam int ASCII_W     = 7;

  localparam logic FONT_16X8 = 1'b1;
  localparam logic FONT_12X6 = 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    ACK   = 2'd3
  } arb_state_e;

  typedef struct packed {
    logic [ASCII_W-1:0]     ascii;
    logic [LCD_COORD_W-1:0] x;
    logic [LCD_COORD_W-1:0] y;
    logic                   size;
  } char_req_t;

  function automatic char_req_t pack_req(
    input logic [ASCII_W-1:0]     ascii,
    input logic [LCD_COORD_W-1:0] x,
    input logic [LCD_COORD_W-1:0] y,
    input logic                   size
  );
    char_req_t r;
    r.ascii = ascii;
    r.x     = x;
    r.y     = y;
    r.size  = size;
    return r;
  endfunction

endpackage

// File: rtl/lcd_char_arbiter_if.sv
// Bundle between the two character producers, the arbiter and the LCD
// character-draw engine.
//   slave  : arbiter view (takes requests + engine done, drives draw bus,
//            acks, busy, timeout_err)
//   master : environment view (requesters and engine), the opposite directions
interface lcd_char_arbiter_if;
  import lcd_char_arbiter_pkg::*;

  logic                   init_done;

  logic                   req0_valid;
  logic [ASCII_W-1:0]     req0_ascii;
  logic [LCD_COORD_W-1:0] req0_x;
  logic [LCD_COORD_W-1:0] req0_y;
  logic                   req0_size;
  logic                   req0_ack;

  logic                   req1_valid;
  logic [ASCII_W-1:0]     req1_ascii;
  logic [LCD_COORD_W-1:0] req1_x;
  logic [LCD_COORD_W-1:0] req1_y;
  logic                   req1_size;
  logic                   req1_ack;

  logic                   show_char_done;
  logic                   show_char_flag;
  logic [ASCII_W-1:0]     ascii_num;
  logic [LCD_COORD_W-1:0] start_x;
  logic [LCD_COORD_W-1:0] start_y;
  logic                   en_size;

  logic                   busy;
  logic                   timeout_err;

  modport slave (
    input  init_done,
    input  req0_valid, req0_ascii, req0_x, req0_y, req0_size,
    output req0_ack,
    input  req1_valid, req1_ascii, req1_x, req1_y, req1_size,
    output req1_ack,
    input  show_char_done,
    output show_char_flag, ascii_num, start_x, start_y, en_size,
    output busy, timeout_err
  );

  modport master (
    output init_done,
    output req0_valid, req0_ascii, req0_x, req0_y, req0_size,
    input  req0_ack,
    output req1_valid, req1_ascii, req1_x, req1_y, req1_size,
    input  req1_ack,
    output show_char_done,
    input  show_char_flag, ascii_num, start_x, start_y, en_size,
    input  busy, timeout_err
  );

endinterface

// File: rtl/lcd_char_arbiter_rr_pick2.sv
// Combinational two-way winner select.
//   v0, v1      : requester valids
//   last_grant  : index of the most recently served requester
//   any_vld     : at least one requester pending
//   winner      : selected requester index (meaningful only when any_vld)
// PRIO_MODE 0 alternates on a tie; PRIO_MODE 1 always favours requester 1.
module lcd_rr_pick2 #(
  parameter int PRIO_MODE = 0
) (
  input  logic v0,
  input  logic v1,
  input  logic last_grant,
  output logic any_vld,
  output logic winner
);

  always_comb begin
    any_vld = v0 | v1;
    winner  = 1'b0;
    if (PRIO_MODE == 1) begin
      winner = v1;
    end else if (v0 && v1) begin
      winner = ~last_grant;
    end else begin
      // single requester pending: it wins; v0-only gives 0, v1-only gives 1
      winner = v1;
    end
  end

endmodule

// File: rtl/lcd_char_arbiter.sv
// Shares one LCD character-draw engine between two character producers
// (req0: banner/label sequencer, req1: live rx-data digit writer).
// A granted request is latched, issued to the engine with a one-cycle
// show_char_flag, and acknowledged one cycle after show_char_done (or after
// a timeout, flagged on timeout_err).
//   sys_clk, sys_rst : clock, asynchronous active-high reset
//   bus (slave)      : requester inputs/acks, engine draw bus, busy,
//                      timeout_err
module lcd_char_arbiter
  import lcd_char_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYC = 65535,
  parameter int CNT_W       = 16,
  parameter int PRIO_MODE   = 0
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  lcd_char_arbiter_if.slave bus
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  arb_state_e       state_q, state_d;
  logic             win_q, win_d;
  logic             last_grant_q, last_grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             flag_q, flag_d;
  logic             ack0_q, ack0_d;
  logic             ack1_q, ack1_d;
  logic             terr_q, terr_d;

  logic             latch_en;
  logic             any_vld;
  logic             pick;
  char_req_t        pick_req;
  char_req_t        char_q;

  lcd_rr_pick2 #(
    .PRIO_MODE (PRIO_MODE)
  ) u_pick (
    .v0         (bus.req0_valid),
    .v1         (bus.req1_valid),
    .last_grant (last_grant_q),
    .any_vld    (any_vld),
    .winner     (pick)
  );

  assign pick_req = pick ? pack_req(bus.req1_ascii, bus.req1_x, bus.req1_y, bus.req1_size)
                         : pack_req(bus.req0_ascii, bus.req0_x, bus.req0_y, bus.req0_size);

  // Next-state and pulse decode. Pulses are computed on the transition into
  // the state that owns them, so each registered pulse is high for exactly
  // that state's single cycle.
  always_comb begin
    state_d      = state_q;
    win_d        = win_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    flag_d       = 1'b0;
    ack0_d       = 1'b0;
    ack1_d       = 1'b0;
    terr_d       = 1'b0;
    latch_en     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.init_done && any_vld) begin
          win_d    = pick;
          latch_en = 1'b1;
          flag_d   = 1'b1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // show_char_done is not looked at here: a stale done from a previous
        // engine operation must not complete this character
        cnt_d   = '0;
        state_d = BUSY;
      end
      BUSY: begin
        cnt_d = cnt_q + CNT_ONE;
        // done takes precedence over a simultaneous timeout
        if (bus.show_char_done) begin
          ack0_d  = ~win_q;
          ack1_d  = win_q;
          state_d = ACK;
        end else if (cnt_q == TMO_LAST) begin
          ack0_d  = ~win_q;
          ack1_d  = win_q;
          terr_d  = 1'b1;
          state_d = ACK;
        end
      end
      ACK: begin
        last_grant_d = win_q;
        cnt_d        = '0;
        state_d      = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control registers
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      win_q        <= 1'b0;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      flag_q       <= 1'b0;
      ack0_q       <= 1'b0;
      ack1_q       <= 1'b0;
      terr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      win_q        <= win_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      flag_q       <= flag_d;
      ack0_q       <= ack0_d;
      ack1_q       <= ack1_d;
      terr_q       <= terr_d;
    end
  end

  // Latched draw parameters: held until the next grant, cleared only by reset
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      char_q <= pack_req('0, '0, '0, FONT_12X6);
    end else if (latch_en) begin
      char_q <= pick_req;
    end
  end

  assign bus.show_char_flag = flag_q;
  assign bus.req0_ack       = ack0_q;
  assign bus.req1_ack       = ack1_q;
  assign bus.timeout_err    = terr_q;
  assign bus.ascii_num      = char_q.ascii;
  assign bus.start_x        = char_q.x;
  assign bus.start_y        = char_q.y;
  assign bus.en_size        = char_q.size;
  assign bus.busy           = (state_q != IDLE);

endmodule
